// File: rtl/pool1_pkg.sv
// Shared defaults and FSM state encoding for the pool1 max-pooling stage.
// POOL1_MAXPOOL_RELU_EN (optional) clamps pooled outputs at zero in pool1_maxpool.
package pool1_pkg;

  localparam int BITS     = 16;
  localparam int CH_NUM   = 16;
  localparam int IMG_W    = 58;
  localparam int IMG_H    = 58;
  localparam int HOLD_CYC = 6;

  localparam logic [0:0] ACCEPT = 1'b0;
  localparam logic [0:0] HOLD   = 1'b1;

endpackage

// File: rtl/pool1_vmax.sv
// Per-channel signed maximum of two packed pixel vectors (purely combinational).
module pool1_vmax
  import pool1_pkg::*;
#(
  parameter int BITS   = pool1_pkg::BITS,
  parameter int CH_NUM = pool1_pkg::CH_NUM
) (
  input  logic [CH_NUM*BITS-1:0] a,
  input  logic [CH_NUM*BITS-1:0] b,
  output logic [CH_NUM*BITS-1:0] y
);

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    assign y[c*BITS +: BITS] = ($signed(a[c*BITS +: BITS]) >= $signed(b[c*BITS +: BITS]))
                               ? a[c*BITS +: BITS] : b[c*BITS +: BITS];
  end

endmodule

// File: rtl/pool1_maxpool.sv
// 2x2 stride-2 max pooling over a raster pixel stream, one line buffer of horizontal maxima.
// Define POOL1_MAXPOOL_RELU_EN to clamp every pooled channel at zero before data_out.
module pool1_maxpool
  import pool1_pkg::*;
#(
  parameter int BITS     = pool1_pkg::BITS,
  parameter int CH_NUM   = pool1_pkg::CH_NUM,
  parameter int IMG_W    = pool1_pkg::IMG_W,
  parameter int IMG_H    = pool1_pkg::IMG_H,
  parameter int HOLD_CYC = pool1_pkg::HOLD_CYC
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH_NUM*BITS-1:0] data_in,
  output logic [CH_NUM*BITS-1:0] data_out,
  output logic                   out_start,
  output logic                   frame_done
);

  localparam int PW   = CH_NUM * BITS;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int HW   = $clog2(HOLD_CYC + 1);
  localparam int LB_D = IMG_W / 2;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  logic [0:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [HW-1:0] hold_cnt;
  logic [PW-1:0] pair_reg;
  logic [PW-1:0] line_buf [LB_D];
  logic [PW-1:0] lb_rd;
  logic [PW-1:0] hmax;
  logic [PW-1:0] vmax_res;
  logic [PW-1:0] result;
  logic [CW-2:0] lb_idx;
  logic          xfer;

  // Ready is forced low while reset is held so nothing is taken during reset.
  assign in_ready = rst_n && (state == ACCEPT);
  assign xfer     = in_valid && in_ready;
  assign lb_idx   = col[CW-1:1];
  assign lb_rd    = line_buf[lb_idx];

  pool1_vmax #(.BITS(BITS), .CH_NUM(CH_NUM)) u_hmax (
    .a(pair_reg),
    .b(data_in),
    .y(hmax)
  );

  pool1_vmax #(.BITS(BITS), .CH_NUM(CH_NUM)) u_vmax (
    .a(hmax),
    .b(lb_rd),
    .y(vmax_res)
  );

`ifdef POOL1_MAXPOOL_RELU_EN
  for (genvar c = 0; c < CH_NUM; c++) begin : g_relu
    assign result[c*BITS +: BITS] = vmax_res[c*BITS + BITS - 1] ? '0 : vmax_res[c*BITS +: BITS];
  end
`else
  assign result = vmax_res;
`endif

  // Pixel pair and line buffer need no reset: each entry is rewritten before it is read.
  always_ff @(posedge clk_in) begin
    if (xfer) begin
      if (!col[0]) begin
        pair_reg <= data_in;
      end else if (!row[0]) begin
        line_buf[lb_idx] <= hmax;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state      <= ACCEPT;
      col        <= '0;
      row        <= '0;
      hold_cnt   <= '0;
      out_start  <= 1'b0;
      frame_done <= 1'b0;
      data_out   <= '0;
    end else begin
      out_start  <= 1'b0;
      frame_done <= 1'b0;

      if (state == HOLD) begin
        if (hold_cnt == HOLD_LAST) begin
          state    <= ACCEPT;
          hold_cnt <= '0;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end

      if (xfer) begin
        col <= (col == COL_LAST) ? '0 : col + 1'b1;
        if (col == COL_LAST) begin
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end
        // Bottom-right pixel of a window completes one pooled output.
        if (col[0] && row[0]) begin
          data_out   <= result;
          out_start  <= 1'b1;
          frame_done <= (col == COL_LAST) && (row == ROW_LAST);
          state      <= HOLD;
          hold_cnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool1_maxpool.sv
// Randomised self-checking bench for pool1_maxpool: a 4x4 instance for directed frames
// and a 58x58 instance for full-size frames, both checked against a window-max model.
module tb_pool1_maxpool;

  localparam int BITS = 16;
  localparam int CH   = 16;
  localparam int PW   = CH * BITS;
  localparam int HOLD = 6;
  localparam int BW   = 58;

  typedef struct {
    logic [PW-1:0] data;
    logic          fdone;
    int            xfers;
  } obs_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          rst_n;
  logic          sel;
  logic          in_valid;
  logic [PW-1:0] data_in;
  logic          s_valid, b_valid;
  logic          s_ready, b_ready, s_start, b_start, s_fdone, b_fdone;
  logic [PW-1:0] s_dout, b_dout;
  logic          cur_ready, cur_start, cur_fdone;
  logic [PW-1:0] cur_dout;

  assign s_valid   = in_valid && !sel;
  assign b_valid   = in_valid && sel;
  assign cur_ready = sel ? b_ready : s_ready;
  assign cur_start = sel ? b_start : s_start;
  assign cur_fdone = sel ? b_fdone : s_fdone;
  assign cur_dout  = sel ? b_dout : s_dout;

  pool1_maxpool #(.BITS(BITS), .CH_NUM(CH), .IMG_W(4), .IMG_H(4), .HOLD_CYC(HOLD)) u_small (
    .clk_in(clk_in), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready),
    .data_in(data_in), .data_out(s_dout), .out_start(s_start), .frame_done(s_fdone)
  );

  pool1_maxpool #(.BITS(BITS), .CH_NUM(CH), .IMG_W(BW), .IMG_H(BW), .HOLD_CYC(HOLD)) u_big (
    .clk_in(clk_in), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .data_in(data_in), .data_out(b_dout), .out_start(b_start), .frame_done(b_fdone)
  );

  logic [PW-1:0] frame [0:BW-1][0:BW-1];
  obs_t          obs_q[$];
  int            compared = 0;
  int            mismatched = 0;
  int            xfers = 0;
  int            frame_base = 0;

`ifdef POOL1_MAXPOOL_RELU_EN
  localparam logic [15:0] WIN_EXP = 16'h0000;
`else
  localparam logic [15:0] WIN_EXP = 16'hFFFF;
`endif

  task automatic checkOutput(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: max of the four window pixels per channel, using plain integer arithmetic.
  function automatic logic [PW-1:0] expectedPool(input int pr, input int pc);
    logic [PW-1:0] res;
    int best, v;
    res = '0;
    for (int c = 0; c < CH; c++) begin
      best = -100000;
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++) begin
          v = int'($signed(frame[2*pr+dy][2*pc+dx][c*BITS +: BITS]));
          if (v > best) best = v;
        end
`ifdef POOL1_MAXPOOL_RELU_EN
      if (best < 0) best = 0;
`endif
      res[c*BITS +: BITS] = 16'(best);
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] randomPixel();
    logic [PW-1:0] px;
    int k;
    for (int c = 0; c < CH; c++) begin
      k = int'($urandom_range(0, 7));
      px[c*BITS +: BITS] = (k == 0) ? 16'h8000 : (k == 1) ? 16'h7FFF :
                           (k == 2) ? 16'hFFFF : 16'($urandom);
    end
    return px;
  endfunction

  always @(posedge clk_in) begin
    if (!rst_n) xfers <= 0;
    else if (in_valid && cur_ready) xfers <= xfers + 1;
  end

  // Output monitor: captures each pulse and checks hold length and data stability.
  initial begin
    bit            tracking;
    int            hcnt;
    logic [PW-1:0] held;
    tracking = 1'b0;
    hcnt = 0;
    held = '0;
    forever begin
      @(negedge clk_in);
      if (!rst_n) begin
        tracking = 1'b0;
      end else begin
        if (tracking) begin
          if (!cur_ready) begin
            hcnt++;
            checkOutput("hold_stable", cur_dout, held);
          end else begin
            checkOutput("hold_len", PW'(hcnt), PW'(HOLD));
            tracking = 1'b0;
          end
        end
        if (cur_start) begin
          obs_q.push_back('{cur_dout, cur_fdone, xfers});
          tracking = 1'b1;
          hcnt = 1;
          held = cur_dout;
        end else if (cur_fdone) begin
          checkOutput("fdone_alone", PW'(cur_fdone), PW'(0));
        end
      end
    end
  end

  // Offers one pixel; junk is driven while the DUT is not ready and must be ignored.
  task automatic applyStimulus(input int r, input int x, input logic [PW-1:0] px, input int gap);
    int tries;
    frame[r][x] = px;
    repeat (gap) begin
      in_valid = 1'b0;
      data_in  = randomPixel();
      @(negedge clk_in);
    end
    in_valid = 1'b1;
    tries = 0;
    while (!cur_ready && tries < 200) begin
      data_in = randomPixel();
      @(negedge clk_in);
      tries++;
    end
    if (tries >= 200) begin
      checkOutput("ready_timeout", PW'(0), PW'(1));
      in_valid = 1'b0;
      return;
    end
    data_in = px;
    @(negedge clk_in);
  endtask

  task automatic runFrame(input int w, input int h, input int mode, input bit gaps, input int stop_after);
    logic [PW-1:0] px;
    logic [15:0]   win [4];
    int            gap;
    win = '{16'hFFFD, 16'hFFFF, 16'hFFF9, 16'h8000};
    frame_base = xfers;
    for (int r = 0; r < h; r++) begin
      for (int x = 0; x < w; x++) begin
        if (r * w + x >= stop_after) begin
          in_valid = 1'b0;
          return;
        end
        px = randomPixel();
        for (int c = 0; c < CH; c++) begin
          if (mode == 0) px[c*BITS +: BITS] = 16'(r * 4 + x + c);
          else if (mode == 1 && r < 2 && x < 2) px[c*BITS +: BITS] = win[r*2+x];
        end
        gap = (gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        applyStimulus(r, x, px, gap);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic checkFrame(input int w, input int h, input int base);
    int n;
    int pr, pc;
    n = (w / 2) * (h / 2);
    checkOutput("out_count", PW'(obs_q.size()), PW'(n));
    for (int i = 0; i < obs_q.size() && i < n; i++) begin
      pr = i / (w / 2);
      pc = i % (w / 2);
      checkOutput("pool_data", obs_q[i].data, expectedPool(pr, pc));
      checkOutput("frame_done", PW'(obs_q[i].fdone), PW'(i == n - 1));
      checkOutput("latency", PW'(obs_q[i].xfers - base), PW'((2*pr+1)*w + 2*pc + 2));
    end
    obs_q.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, PW'(cur_ready), PW'(0));
    checkOutput({tag, "_start"}, PW'(cur_start), PW'(0));
    checkOutput({tag, "_fdone"}, PW'(cur_fdone), PW'(0));
    checkOutput({tag, "_dout"}, cur_dout, PW'(0));
  endtask

  initial begin
    int exp0 [4];
    int base;
    exp0 = '{5, 7, 13, 15};
    rst_n = 1'b0;
    sel = 1'b0;
    in_valid = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk_in);
    checkResetState("rst_small");
    sel = 1'b1;
    #1 checkResetState("rst_big");
    sel = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_rst_small", PW'(s_ready), PW'(1));
    checkOutput("ready_after_rst_big", PW'(b_ready), PW'(1));
    @(negedge clk_in);

    $display("[TB] 4x4 ramp frame, continuous valid");
    runFrame(4, 4, 0, 1'b0, 1 << 30);
    repeat (12) @(negedge clk_in);
    checkOutput("accepted", PW'(xfers), PW'(16));
    for (int i = 0; i < 4 && i < obs_q.size(); i++)
      checkOutput("ramp_ch0", PW'(obs_q[i].data[15:0]), PW'(exp0[i]));
    checkFrame(4, 4, frame_base);

    $display("[TB] 4x4 negative-window frame, back to back");
    runFrame(4, 4, 1, 1'b0, 1 << 30);
    repeat (12) @(negedge clk_in);
    if (obs_q.size() > 0) begin
      checkOutput("win_ch0", PW'(obs_q[0].data[15:0]), PW'(WIN_EXP));
      checkOutput("win_ch15", PW'(obs_q[0].data[PW-1 -: 16]), PW'(WIN_EXP));
    end
    checkFrame(4, 4, frame_base);

    $display("[TB] 58x58 random frame with valid gaps");
    sel = 1'b1;
    @(negedge clk_in);
    runFrame(BW, BW, 2, 1'b1, 1 << 30);
    repeat (12) @(negedge clk_in);
    checkFrame(BW, BW, frame_base);

    $display("[TB] reset in the middle of row 3, then a fresh frame");
    runFrame(BW, BW, 2, 1'b1, 3 * BW + 20);
    repeat (12) @(negedge clk_in);
    obs_q.delete();
    rst_n = 1'b0;
    @(negedge clk_in);
    checkResetState("midrst");
    rst_n = 1'b1;
    #1 checkOutput("midrst_ready_after", PW'(cur_ready), PW'(1));
    @(negedge clk_in);
    base = xfers;
    checkOutput("midrst_xfers", PW'(base), PW'(0));
    runFrame(BW, BW, 2, 1'b1, 1 << 30);
    repeat (12) @(negedge clk_in);
    checkFrame(BW, BW, frame_base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
